// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-serial image loader into instruction memory with XOR checksum; BOOT_TIMEOUT_EN enables the idle timeout
module imem_boot_loader #(
  parameter int IMEM_SIZE      = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [0:7]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [0:31] imem_waddr,
  output logic [0:31] imem_wdata,
  output logic        proc_reset,
  output logic        done,
  output logic        error,
  output logic [0:1]  error_code
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR} state_t;
  localparam logic [16:0] MAX_WORDS = 17'(IMEM_SIZE / 4);
  state_t      state, state_d;
  logic [15:0] n, idx, n_full;
  logic [1:0]  bcnt, code_d;
  logic [23:0] asm_word;
  logic [7:0]  csum;
  logic        accept, hdr, word_done, last_word, active, tmo;
  assign accept    = rx_valid & rx_ready;
  assign hdr       = state == IDLE && accept && rx_data == 8'hA5;
  assign n_full    = {n[15:8], rx_data};
  assign word_done = state == DATA && accept && bcnt == 2'd3;
  assign last_word = idx == n - 16'd1;
  assign active    = state inside {LEN_HI, LEN_LO, DATA, CSUM};
`ifdef BOOT_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  logic [15:0] timer;
  // idle-cycle counter, restarted by every accepted byte and parked outside the frame states
  always_ff @(posedge clock) begin
    if (!reset || accept || !active) timer <= '0;
    else if (timer != TMO) timer <= timer + 16'd1;
  end
  assign tmo = active && !accept && timer == TMO;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign tmo = 1'b0 & active;
`endif
  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end
  // next-state and error cause; RUN and ERR are terminal since rx_ready is low there
  always_comb begin
    state_d = state;
    code_d  = error_code;
    if (tmo) begin
      state_d = ERR;
      code_d  = 2'b11;
    end else if (accept) begin
      case (state)
        IDLE:   state_d = rx_data == 8'hA5 ? LEN_HI : IDLE;
        LEN_HI: state_d = LEN_LO;
        LEN_LO: begin
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = ERR;
            code_d  = 2'b10;
          end else begin
            state_d = n_full == 16'd0 ? CSUM : DATA;
          end
        end
        DATA:   state_d = bcnt == 2'd3 && last_word ? CSUM : DATA;
        CSUM: begin
          state_d = rx_data == csum ? RUN : ERR;
          code_d  = rx_data == csum ? error_code : 2'b01;
        end
        default: state_d = state;
      endcase
    end
  end
  // frame datapath: length, word assembly, running checksum and word index
  always_ff @(posedge clock) begin
    if (!reset) begin
      n        <= '0;
      idx      <= '0;
      bcnt     <= '0;
      asm_word <= '0;
      csum     <= '0;
    end else begin
      if (hdr) begin
        idx      <= '0;
        bcnt     <= '0;
        asm_word <= '0;
        csum     <= '0;
      end
      if (state == LEN_HI && accept) n[15:8] <= rx_data;
      if (state == LEN_LO && accept) n[7:0] <= rx_data;
      if (state == DATA && accept) begin
        asm_word <= {asm_word[15:0], rx_data};
        csum     <= csum ^ rx_data;
        bcnt     <= bcnt + 2'd1;
      end
      if (word_done) idx <= idx + 16'd1;
    end
  end
  // registered outputs, decoded from the state being entered so they line up with it
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      proc_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= 2'b00;
    end else begin
      rx_ready   <= state_d inside {IDLE, LEN_HI, LEN_LO, DATA, CSUM};
      imem_we    <= word_done;
      if (word_done) begin
        imem_waddr <= {14'd0, idx, 2'b00};
        imem_wdata <= {asm_word, rx_data};
      end
      proc_reset <= state_d != RUN;
      done       <= state_d == RUN;
      error      <= state_d == ERR;
      error_code <= code_d;
    end
  end
endmodule
